// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph table, monitor FSM encoding and expected-next-digit helper.
package seg7_pkg;
  typedef enum logic [1:0] {S_WAIT, S_QUAL, S_HOLD} state_t;
  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic logic [3:0] next_digit(input logic [3:0] prev, input logic [3:0] wrap_max);
    return (prev == wrap_max) ? 4'd0 : prev + 4'd1;
  endfunction
endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: maps a segment pattern to its hex digit; unknown patterns give known=0, digit=0.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_digit,
  output logic       o_known
);
  always_comb begin
    o_digit = '0;
    o_known = 1'b0;
    for (int i = 0; i < 16; i++)
      if (i_seg == GLYPHS[4'(i)]) begin
        o_digit = 4'(i);
        o_known = 1'b1;
      end
  end
endmodule

// File: rtl/seg7_monitor.sv
// seg7_monitor: qualifies a stable 7-segment pattern, decodes it and flags counting-sequence errors.
// Define SEG7_MONITOR_PERIOD_EN to add the inter-acceptance period measurement.
module seg7_monitor
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int PERIOD_W      = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          seg_in,
  input  logic [3:0]          wrap_max_i,
  output logic                valid_o,
  output logic [3:0]          digit_o,
  output logic                known_o,
  output logic                seq_err_o,
  output logic [PERIOD_W-1:0] period_o,
  output logic                period_valid_o
);
  localparam logic [3:0] LAST = 4'(STABLE_CYCLES - 1);
  state_t     r_state, w_next;
  logic [6:0] r_seg_q, r_cand, r_acc;
  logic [3:0] r_cnt, w_run, w_digit;
  logic       r_any, w_diff, w_revert, w_accept, w_known, w_bad;
  seg7_glyph_decode u_dec (.i_seg(r_seg_q), .o_digit(w_digit), .o_known(w_known));
  // r_cnt is the number of cycles seg_q has matched the candidate, minus one
  always_comb begin
    w_diff   = r_seg_q != r_cand;
    w_revert = w_diff && r_seg_q == r_acc;
    w_run    = w_diff ? 4'd0 : r_cnt + 4'd1;
    w_accept = (r_state == S_QUAL || w_diff) && !w_revert && w_run == LAST;
    w_next   = w_accept ? S_HOLD : w_revert ? (r_any ? S_HOLD : S_WAIT) : w_diff ? S_QUAL : r_state;
    w_bad    = w_known && known_o && w_digit != next_digit(digit_o, wrap_max_i);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_WAIT;
      r_seg_q   <= '0;
      r_cand    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_any     <= 1'b0;
      valid_o   <= 1'b0;
      digit_o   <= '0;
      known_o   <= 1'b0;
      seq_err_o <= 1'b0;
    end else begin
      r_state <= w_next;
      r_seg_q <= seg_in;
      r_cand  <= r_seg_q;
      r_cnt   <= w_run;
      valid_o <= w_accept;
      if (w_accept) begin
        r_acc     <= r_seg_q;
        r_any     <= 1'b1;
        digit_o   <= w_digit;
        known_o   <= w_known;
        seq_err_o <= seq_err_o | w_bad;
      end
    end
  end
`ifdef SEG7_MONITOR_PERIOD_EN
  logic [PERIOD_W-1:0] r_per_cnt, w_per_inc;
  assign w_per_inc = &r_per_cnt ? r_per_cnt : r_per_cnt + PERIOD_W'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_per_cnt      <= '0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
    end else if (w_accept) begin
      r_per_cnt      <= '0;
      period_o       <= w_per_inc;
      period_valid_o <= period_valid_o | r_any;
    end else begin
      r_per_cnt <= w_per_inc;
    end
  end
`else
  assign period_o       = '0;
  assign period_valid_o = 1'b0;
`endif
endmodule

// File: tb/tb_seg7_monitor.sv
// tb_seg7_monitor: directed scenarios plus randomized patterns checked against a run-length reference model.
module tb_seg7_monitor;
  import seg7_pkg::*;
  localparam int S  = 4;
  localparam int PW = 24;
  localparam int CAP = (1 << PW) - 1;
  logic clk = 0, reset = 1;
  logic [6:0] seg_in = '0;
  logic [3:0] wrap_max_i = 4'd9;
  logic valid_o, known_o, seq_err_o, period_valid_o;
  logic [3:0] digit_o;
  logic [PW-1:0] period_o;
  int total = 0, bad = 0;
  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [6:0] m_segq, m_seen, m_acc;
  int m_run, m_digit, m_pcnt, m_period;
  logic m_any, m_valid, m_known, m_err, m_pvalid;

  always #5 clk = ~clk;

  seg7_monitor #(.STABLE_CYCLES(S), .PERIOD_W(PW)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .wrap_max_i(wrap_max_i),
    .valid_o(valid_o), .digit_o(digit_o), .known_o(known_o), .seq_err_o(seq_err_o),
    .period_o(period_o), .period_valid_o(period_valid_o)
  );

  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (tbl[i] == p) return i;
    return -1;
  endfunction

  // Acceptance = the registered pattern has been seen for exactly S consecutive cycles and differs from the last accepted one.
  task automatic model_step();
    logic [6:0] v;
    int d, nxt;
    if (reset) begin
      m_segq = '0; m_seen = '0; m_acc = '0; m_run = 0; m_any = 0; m_valid = 0;
      m_digit = 0; m_known = 0; m_err = 0; m_pcnt = 0; m_period = 0; m_pvalid = 0;
    end else begin
      v = m_segq;
      m_run = (v == m_seen) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
      m_seen = v;
      m_valid = (m_run == S) && (v != m_acc);
      if (m_valid) begin
        d = decode(v);
        nxt = (m_digit == int'(wrap_max_i)) ? 0 : (m_digit + 1) % 16;
        if (d >= 0 && m_known && d != nxt) m_err = 1;
        m_known = d >= 0;
        m_digit = (d >= 0) ? d : 0;
`ifdef SEG7_MONITOR_PERIOD_EN
        m_period = (m_pcnt + 1 > CAP) ? CAP : m_pcnt + 1;
        if (m_any) m_pvalid = 1;
`endif
        m_pcnt = 0;
        m_acc = v;
        m_any = 1;
      end else begin
        m_pcnt = (m_pcnt + 1 > CAP) ? CAP : m_pcnt + 1;
      end
      m_segq = seg_in;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    seg_in = 7'h06;
    do_reset();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset valid_o got %b want 0", valid_o); end
    total++; if (digit_o !== 4'd0) begin bad++; $display("FAIL reset digit_o got %h want 0", digit_o); end
    total++; if (known_o !== 1'b0) begin bad++; $display("FAIL reset known_o got %b want 0", known_o); end
    total++; if (seq_err_o !== 1'b0) begin bad++; $display("FAIL reset seq_err_o got %b want 0", seq_err_o); end
    total++; if (period_o !== '0) begin bad++; $display("FAIL reset period_o got %0d want 0", period_o); end
    total++; if (period_valid_o !== 1'b0) begin bad++; $display("FAIL reset period_valid_o got %b want 0", period_valid_o); end
  endtask

  task automatic test_stable();
    int first = -1, pulses = 0;
    seg_in = '0;
    do_reset();
    repeat (5) tick();
    seg_in = 7'h06;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (valid_o) begin pulses++; if (first < 0) first = i; end
    end
    total++; if (first !== S) begin bad++; $display("FAIL stable latency got %0d want %0d", first, S); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL stable pulses got %0d want 1", pulses); end
    total++; if (digit_o !== 4'd1) begin bad++; $display("FAIL stable digit got %h want 1", digit_o); end
    total++; if (known_o !== 1'b1) begin bad++; $display("FAIL stable known got %b want 1", known_o); end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    seg_in = 7'h5B;
    for (int i = 0; i < 3; i++) begin tick(); if (valid_o) pulses++; end
    seg_in = 7'h06;
    for (int i = 0; i < 20; i++) begin tick(); if (valid_o) pulses++; end
    total++; if (pulses !== 0) begin bad++; $display("FAIL glitch pulses got %0d want 0", pulses); end
    total++; if (digit_o !== 4'd1) begin bad++; $display("FAIL glitch digit got %h want 1", digit_o); end
  endtask

  task automatic test_wrap();
    int pulses = 0;
    int seq [3] = '{4, 5, 0};
    seg_in = '0;
    wrap_max_i = 4'd5;
    do_reset();
    for (int j = 0; j < 3; j++) begin
      seg_in = tbl[seq[j]];
      for (int i = 0; i < 20; i++) begin tick(); if (valid_o) pulses++; end
    end
    total++; if (pulses !== 3) begin bad++; $display("FAIL wrap pulses got %0d want 3", pulses); end
    total++; if (seq_err_o !== 1'b0) begin bad++; $display("FAIL wrap seq_err got %b want 0", seq_err_o); end
    total++; if (digit_o !== 4'd0) begin bad++; $display("FAIL wrap digit got %h want 0", digit_o); end
  endtask

  task automatic test_skip();
    seg_in = '0;
    wrap_max_i = 4'd9;
    do_reset();
    seg_in = tbl[2];
    repeat (20) tick();
    total++; if (seq_err_o !== 1'b0) begin bad++; $display("FAIL skip first-acc seq_err got %b want 0", seq_err_o); end
    seg_in = tbl[4];
    repeat (20) tick();
    total++; if (seq_err_o !== 1'b1) begin bad++; $display("FAIL skip seq_err got %b want 1", seq_err_o); end
    total++; if (digit_o !== 4'd4) begin bad++; $display("FAIL skip digit got %h want 4", digit_o); end
    seg_in = 7'h00;
    repeat (20) tick();
    total++; if (known_o !== 1'b0) begin bad++; $display("FAIL skip blank known got %b want 0", known_o); end
    seg_in = 7'h3F;
    repeat (20) tick();
    total++; if (seq_err_o !== 1'b1) begin bad++; $display("FAIL skip sticky seq_err got %b want 1", seq_err_o); end
    total++; if (digit_o !== 4'd0 || known_o !== 1'b1) begin bad++; $display("FAIL skip last digit got %h/%b want 0/1", digit_o, known_o); end
  endtask

  task automatic test_period();
    seg_in = '0;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      seg_in = (n % 2) ? 7'h06 : 7'h3F;
      repeat (100) tick();
`ifdef SEG7_MONITOR_PERIOD_EN
      if (n == 0) begin
        total++; if (period_valid_o !== 1'b0) begin bad++; $display("FAIL period first-acc valid got %b want 0", period_valid_o); end
      end
`endif
    end
`ifdef SEG7_MONITOR_PERIOD_EN
    total++; if (period_o !== PW'(100)) begin bad++; $display("FAIL period value got %0d want 100", period_o); end
    total++; if (period_valid_o !== 1'b1) begin bad++; $display("FAIL period valid got %b want 1", period_valid_o); end
`else
    total++; if (period_o !== '0) begin bad++; $display("FAIL period tied got %0d want 0", period_o); end
    total++; if (period_valid_o !== 1'b0) begin bad++; $display("FAIL period_valid tied got %b want 0", period_valid_o); end
`endif
    do_reset();
    total++; if (period_o !== '0 || period_valid_o !== 1'b0) begin bad++; $display("FAIL period after reset got %0d/%b want 0/0", period_o, period_valid_o); end
  endtask

  task automatic test_reset_midqual();
    int pulses = 0;
    seg_in = '0;
    do_reset();
    seg_in = 7'h4F;
    repeat (3) tick();
    reset = 1;
    seg_in = '0;
    tick();
    reset = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (valid_o) pulses++; end
    total++; if (pulses !== 0) begin bad++; $display("FAIL midqual pulses got %0d want 0", pulses); end
    total++; if (digit_o !== 4'd0 || known_o !== 1'b0 || seq_err_o !== 1'b0) begin bad++; $display("FAIL midqual outputs got %h/%b/%b want 0/0/0", digit_o, known_o, seq_err_o); end
    total++; if (dut.r_state !== S_WAIT) begin bad++; $display("FAIL midqual state got %0d want WAIT", dut.r_state); end
  endtask

  task automatic test_random();
    int r, hold;
    seg_in = '0;
    wrap_max_i = 4'd9;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 5) seg_in = tbl[(m_digit == int'(wrap_max_i)) ? 0 : (m_digit + 1) % 16];
      else if (r < 7) seg_in = tbl[$urandom_range(0, 15)];
      else if (r < 8) seg_in = 7'h00;
      else seg_in = 7'($urandom);
      if ($urandom_range(0, 9) == 0) wrap_max_i = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 49) == 0);
      hold = $urandom_range(1, 8);
      for (int i = 0; i < hold; i++) begin
        tick();
        reset = 0;
        total++; if (valid_o !== m_valid) begin bad++; $display("FAIL rnd valid_o t=%0t got %b want %b", $time, valid_o, m_valid); end
        total++; if (digit_o !== 4'(m_digit)) begin bad++; $display("FAIL rnd digit_o t=%0t got %h want %h", $time, digit_o, m_digit); end
        total++; if (known_o !== m_known) begin bad++; $display("FAIL rnd known_o t=%0t got %b want %b", $time, known_o, m_known); end
        total++; if (seq_err_o !== m_err) begin bad++; $display("FAIL rnd seq_err_o t=%0t got %b want %b", $time, seq_err_o, m_err); end
        total++; if (period_o !== PW'(m_period)) begin bad++; $display("FAIL rnd period_o t=%0t got %0d want %0d", $time, period_o, m_period); end
        total++; if (period_valid_o !== m_pvalid) begin bad++; $display("FAIL rnd period_valid_o t=%0t got %b want %b", $time, period_valid_o, m_pvalid); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stable();
    test_glitch();
    test_wrap();
    test_skip();
    test_period();
    test_reset_midqual();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg7_monitor.md
SEG7_MONITOR -- requirements
Module: seg7_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: cycles a pattern must hold before acceptance; legal range 1..15.
REQ-002 SHALL have parameter PERIOD_W, default 24: width of the period counter and period_o.
REQ-003 SHALL have port clk, input, 1: clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port seg_in, input, 7: observed segment bus; bit0=a through bit6=g, active-high.
REQ-006 SHALL have port wrap_max_i, input, 4: highest digit of the expected counting sequence.
REQ-007 SHALL have port valid_o, output, 1: one-cycle pulse when a new pattern is accepted.
REQ-008 SHALL have port digit_o, output, 4: decoded value of the accepted pattern.
REQ-009 SHALL have port known_o, output, 1: accepted pattern is a hex glyph.
REQ-010 SHALL have port seq_err_o, output, 1: sticky flag for a sequence violation.
REQ-011 SHALL have port period_o, output, PERIOD_W: cycles between the last two acceptances.
REQ-012 SHALL have port period_valid_o, output, 1: period_o holds a real measurement.

Function
REQ-013 SHALL register seg_in once (seg_q) before any comparison.
REQ-014 SHALL run a three-state FSM:
- WAIT: nothing accepted since reset.
- QUAL: candidate differs from the accepted pattern; stability count running.
- HOLD: candidate equals the accepted pattern.
REQ-015 SHALL, whenever seg_q differs from the candidate, load the candidate from seg_q, clear the stability count and enter QUAL (from WAIT or HOLD, or restart within QUAL).
REQ-016 SHALL accept the candidate when it has been unchanged for STABLE_CYCLES consecutive cycles; valid_o then pulses.
- Latency: a value held on seg_in from edge k pulses valid_o in the cycle after edge k+STABLE_CYCLES.
REQ-017 SHALL treat a glitch shorter than STABLE_CYCLES as no change: no valid_o, and return to HOLD if seg_q reverts to the accepted pattern.
REQ-018 SHALL decode using the hex glyph table: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71.
- Glyph match: known_o=1 and digit_o=value.
- No match (including 00): known_o=0 and digit_o=0.
- known_o and digit_o update with valid_o and hold until the next acceptance.
REQ-019 SHALL compute the expected next digit as 0 if the previous digit equals wrap_max_i, else previous+1 (4-bit).
REQ-020 SHALL set seq_err_o when a known digit is accepted, the previous acceptance was known, and the digit differs from the expected next digit.
REQ-021 SHALL NOT check the first acceptance after reset, nor a known digit that follows an unknown one.
REQ-022 SHALL keep seq_err_o set until reset.

Reset
REQ-023 SHALL, on reset, drive valid_o=0, digit_o=0, known_o=0, seq_err_o=0, period_o=0 and period_valid_o=0.
REQ-024 SHALL, on reset, clear the candidate, the accepted pattern and the stability count, and enter WAIT.
REQ-025 SHALL abandon any in-progress qualification on reset asserted mid-QUAL, with no valid_o pulse.

Configuration
REQ-026 SHALL, with macro SEG7_MONITOR_PERIOD_EN defined, implement the period measurement:
- A counter increments every cycle and saturates at all-ones.
- On each acceptance, period_o loads counter+1 (saturating) and the counter clears.
- period_valid_o is 1 from the second acceptance after reset onward.
REQ-027 SHALL, without SEG7_MONITOR_PERIOD_EN, tie period_o and period_valid_o to 0 and contain no period counter.

Structure
REQ-028 SHALL place the glyph constants, the FSM state encoding and the expected-next function in shared package seg7_pkg.
REQ-029 SHALL implement glyph-to-digit lookup in one combinational sub-module, seg7_glyph_decode.

Verification
REQ-030 SHALL cover a stable pattern: STABLE_CYCLES=4, seg_in=7'h06 from edge 10 -> valid_o pulse in the cycle after edge 14, digit_o=1, known_o=1.
REQ-031 SHALL cover glitch rejection: accepted 06, seg_in=5B for 3 cycles then back to 06 -> no valid_o, digit_o stays 1.
REQ-032 SHALL cover wrap: wrap_max_i=5, sequence 4,5,0 each held 20 cycles -> three valid_o pulses, seq_err_o=0.
REQ-033 SHALL cover skip detection: sequence 2 then 4 (wrap_max_i=9) -> seq_err_o=1 after the second acceptance, still 1 after 00, 3F.
REQ-034 SHALL cover the period with macro defined: acceptances exactly 100 cycles apart -> period_o=100, period_valid_o=1; reset -> both 0.
REQ-035 SHALL cover reset mid-QUAL: reset 2 cycles into qualification -> no valid_o, all outputs 0, FSM in WAIT.
